// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Multi-precision add/subtract built from one NUMBITS-wide ripple-carry
//   adder. The adder is reused over NWORDS word pairs, least-significant
//   word first. The carry between words is held in a register.
//
// Ports
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   start, sub           : begin an operation (IDLE only); sub=1 selects A-B
//   in_valid, in_ready   : operand word-pair handshake
//   a_word, b_word       : operand words, LSW first
//   out_valid, out_ready : result word handshake (registered output)
//   sum_word, out_last   : result word; out_last marks the MSW
//   carryout, overflow   : final carry and signed overflow, valid with out_last
//   busy, done           : busy in RUN/DRAIN; done pulses after the last word

module ripple_carry_adder #(
  parameter int NUMBITS = 16
) (
  input  logic [NUMBITS-1:0] a,
  input  logic [NUMBITS-1:0] b,
  input  logic               carryin,
  output logic [NUMBITS-1:0] sum,
  output logic               carryout
);
  logic [NUMBITS:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = carryin;
    for (int i = 0; i < NUMBITS; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carryout = c[NUMBITS];
  end
endmodule

module multiword_add_sequencer #(
  parameter int NUMBITS = 16,
  parameter int NWORDS  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sub,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] a_word,
  input  logic [NUMBITS-1:0] b_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] sum_word,
  output logic               out_last,
  output logic               carryout,
  output logic               overflow,
  output logic               busy,
  output logic               done
);
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               op_q, op_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [NUMBITS-1:0] sum_q, sum_d;
  logic               carryout_q, carryout_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic [NUMBITS-1:0] b_eff;
  logic [NUMBITS-1:0] add_sum;
  logic               add_cout;
  logic               in_hs;
  logic               out_hs;

  // Subtraction is A + ~B + 1; the +1 comes from carry_q being seeded with sub.
  assign b_eff = op_q ? ~b_word : b_word;

  ripple_carry_adder #(.NUMBITS(NUMBITS)) u_adder (
    .a        (a_word),
    .b        (b_eff),
    .carryin  (carry_q),
    .sum      (add_sum),
    .carryout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sum_d       = sum_q;
    carryout_d  = carryout_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;

    // The output register can accept a new word when empty or draining now.
    in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    in_hs    = in_valid && in_ready;
    out_hs   = out_valid_q && out_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          carry_d    = sub;
          op_d       = sub;
          idx_d      = '0;
          carryout_d = 1'b0;
          overflow_d = 1'b0;
        end
      end
      RUN: begin
        if (in_hs) begin
          sum_d       = add_sum;
          out_valid_d = 1'b1;
          carry_d     = add_cout;
          idx_d       = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            out_last_d = 1'b1;
            carryout_d = add_cout;
            // Signed overflow: result sign differs from both effective operands.
            overflow_d = (a_word[NUMBITS-1] ^ add_sum[NUMBITS-1]) &
                         (b_eff[NUMBITS-1] ^ add_sum[NUMBITS-1]);
            state_d    = DRAIN;
          end
        end else if (out_hs) begin
          out_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sum_q       <= '0;
      carryout_q  <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sum_q       <= sum_d;
      carryout_q  <= carryout_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sum_word  = sum_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Testbench for multiword_add_sequencer (NUMBITS=16, NWORDS=4).
// Reference model treats each operation as one 64-bit add/subtract.
module tb_multiword_add_sequencer;
  localparam int NB = 16;
  localparam int NW = 4;
  localparam int TW = NB * NW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] a_word;
  logic [NB-1:0] b_word;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] sum_word;
  logic          out_last;
  logic          carryout;
  logic          overflow;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.NUMBITS(NB), .NWORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_word  (sum_word),
    .out_last  (out_last),
    .carryout  (carryout),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-operand arithmetic: unsigned result/carry and signed overflow.
  function automatic void model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s,
                                output logic [TW-1:0] r, output logic co, output logic ov);
    logic [TW:0]          u;
    logic signed [TW+1:0] sa, sb, sr;
    sa = $signed({{2{a[TW-1]}}, a});
    sb = $signed({{2{b[TW-1]}}, b});
    if (s) begin
      u  = {1'b0, a} + {1'b0, ~b} + 1;
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      sr = sa + sb;
    end
    r  = u[TW-1:0];
    co = u[TW];
    ov = (sr[TW+1:TW-1] != 3'b000) && (sr[TW+1:TW-1] != 3'b111);
  endfunction

  // mode 0: out_ready=1; mode 1: out_ready 1,0,0,1 then 1; mode 2: random gaps/stalls
  task automatic run_op(input string nm, input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input logic s, input int mode, input bit ign_start);
    logic [TW-1:0] er;
    logic          eco, eovf;
    logic [3:0]    pat;
    logic [NB-1:0] held;
    logic          stall_prev, exp_ov, exp_ir;
    bit            ihs, ohs;
    int            widx, ridx, cyc;
    model(a, b, s, er, eco, eovf);
    pat = 4'b1001;
    @(negedge clk);
    start = 1'b1; sub = s;
    @(negedge clk);
    start = 1'b0; sub = 1'b0;
    chk({nm, ":busy_run"}, busy, 1);
    widx = 0; ridx = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (ridx < NW && cyc < 200) begin
      in_valid = (widx < NW) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (widx < NW) begin
        a_word = a[widx*NB +: NB];
        b_word = b[widx*NB +: NB];
      end else begin
        a_word = '0;
        b_word = '0;
      end
      if (mode == 1)      out_ready = (cyc < 4) ? pat[cyc] : 1'b1;
      else if (mode == 2) out_ready = ($urandom_range(0, 2) != 0);
      else                out_ready = 1'b1;
      start = ign_start && (cyc == 1);
      sub   = ign_start && (cyc == 1);
      #1;
      exp_ov = (widx > ridx);
      exp_ir = (widx < NW) && (!exp_ov || out_ready);
      chk({nm, ":out_valid"}, out_valid, exp_ov);
      chk({nm, ":in_ready"}, in_ready, exp_ir);
      if (stall_prev) chk({nm, ":stall_hold"}, sum_word, held);
      ihs = in_valid && exp_ir;
      ohs = exp_ov && out_ready;
      if (ohs) begin
        chk({nm, ":sum_word"}, sum_word, er[ridx*NB +: NB]);
        chk({nm, ":out_last"}, out_last, (ridx == NW - 1));
        if (ridx == NW - 1) begin
          chk({nm, ":carryout"}, carryout, eco);
          chk({nm, ":overflow"}, overflow, eovf);
        end
        ridx++;
      end
      stall_prev = exp_ov && !out_ready;
      held = sum_word;
      if (ihs) widx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; sub = 1'b0; in_valid = 1'b0;
    if (cyc >= 200) chk({nm, ":timeout_words"}, ridx, NW);
    chk({nm, ":done"}, done, 1);
    chk({nm, ":busy_at_done"}, busy, 0);
    chk({nm, ":out_valid_after"}, out_valid, 0);
    chk({nm, ":carry_hold"}, carryout, eco);
    chk({nm, ":ovf_hold"}, overflow, eovf);
    @(negedge clk);
    chk({nm, ":done_pulse"}, done, 0);
    chk({nm, ":carry_hold2"}, carryout, eco);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; in_valid = 1'b0;
    a_word = '0; b_word = '0; out_ready = 1'b0;
    #1;
    chk("reset:in_ready", in_ready, 0);
    chk("reset:out_valid", out_valid, 0);
    chk("reset:sum_word", sum_word, 0);
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_chain", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0);
    run_op("sub_borrow", 64'h0, 64'h1, 1'b1, 0, 0);
    run_op("signed_ovf", 64'h7FFF_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, 0, 0);
    run_op("backpressure", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1, 0);
    run_op("ignored_start", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1);
    run_op("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1, 0);

    // Reset in the middle of an operation, after two accepted words.
    @(negedge clk);
    start = 1'b1; sub = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a_word = 16'h1234; b_word = 16'h4321;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:in_ready", in_ready, 0);
    chk("midrst:out_valid", out_valid, 0);
    chk("midrst:out_last", out_last, 0);
    chk("midrst:sum_word", sum_word, 0);
    chk("midrst:carryout", carryout, 0);
    chk("midrst:overflow", overflow, 0);
    chk("midrst:busy", busy, 0);
    chk("midrst:done", done, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 64'h1, 64'h1, 1'b0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      run_op("random", {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequences one `ripple_carry_adder` instance (NUMBITS wide) over NWORDS consecutive word pairs to perform multi-precision add or subtract. Each accepted word pair produces one result word. The carry between words is held in a register. Operands stream in least-significant word first on a valid/ready input port. Results stream out on a registered valid/ready output port. The block sits between an operand source (register file or DMA reader) and the result sink, and is the sole owner of its adder instance.

## Interface
- NUMBITS, 16: word width; passed unchanged to the adder instance.
- NWORDS, 4: words per operation; legal range 2..256.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- sub  in  1  sampled with start; 1 = A−B, 0 = A+B.
- in_valid  in  1  a_word/b_word valid.
- in_ready  out  1  word pair accepted when in_valid && in_ready.
- a_word  in  NUMBITS  A operand word, LSW first.
- b_word  in  NUMBITS  B operand word, LSW first.
- out_valid  out  1  sum_word valid.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- sum_word  out  NUMBITS  result word.
- out_last  out  1  qualifies the final (MSW) result word.
- carryout  out  1  carry out of the MSW; valid with out_last.
- overflow  out  1  signed overflow of the full-width result; valid with out_last.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  single-cycle pulse after the last word is taken.

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE:**
  - start=1 → RUN.
  - carry_q ← sub, op_q ← sub, idx ← 0.
  - start while not in IDLE is ignored.
- **RUN:**
  - Adder inputs: A=a_word, B=op_q ? ~b_word : b_word, carryin=carry_q.
  - in_ready = !out_valid || out_ready.
  - On input handshake:
    - sum_word ← adder result; out_valid ← 1; carry_q ← adder carryout; idx ← idx+1.
    - If idx == NWORDS−1: out_last ← 1, carryout ← adder carryout, overflow ← (a_msb ^ s_msb) & (beff_msb ^ s_msb), state → DRAIN.
- **Output register:**
  - Held stable while out_valid && !out_ready.
  - Cleared (out_valid ← 0) on output handshake with no new input handshake in the same cycle.
- **DRAIN:**
  - in_ready = 0.
  - On output handshake of the last word: out_valid, out_last ← 0; done ← 1 for one cycle; state → IDLE.
- Subtraction: carryout=1 means no borrow (A ≥ B unsigned). overflow uses two's-complement rules on the MSW only.
- carryout and overflow hold their values until the next start.
- Reset (async, any state):
  - state=IDLE; idx=0; carry_q=0.
  - All outputs 0: in_ready, out_valid, out_last, sum_word, carryout, overflow, busy, done.
  - An operation in flight is discarded.

## Timing
- IDLE→RUN: 1 cycle after start. in_ready can assert in the first RUN cycle.
- Latency: input handshake in cycle n → sum_word valid in cycle n+1.
- Throughput: one word per cycle when out_ready is held high. Simultaneous input and output handshakes are allowed in RUN.
- Minimum operation length: 1 (start) + NWORDS + 1 (final drain) cycles. done asserts in the cycle after the last output handshake.
- Backpressure: out_ready=0 drops in_ready combinationally while out_valid=1. No word is lost or duplicated.
- in_valid with no handshake (RUN, in_ready=0) changes no state.
- busy=1 from the cycle after start until the cycle done asserts; busy=0 in that cycle.

## Test plan
- **Add with carry chain.** NWORDS=4, sub=0, A=0x0000_FFFF_FFFF_FFFF, B=1, out_ready=1.
  - Expected words: 0x0000, 0x0000, 0x0000, 0x0001.
  - carryout=0, overflow=0, done one cycle after last word.
- **Subtract with borrow.** sub=1, A=0, B=1.
  - Expected: all words 0xFFFF, carryout=0, overflow=0.
- **Signed overflow.** sub=0, A=0x7FFF_0000_0000_0000, B=0x0001_0000_0000_0000.
  - Expected MSW: 0x8000, overflow=1, carryout=0.
- **Backpressure.** out_ready toggles 1,0,0,1 during the add-with-carry-chain case.
  - sum_word is stable while stalled.
  - in_ready=0 while out_valid && !out_ready.
  - Exactly 4 output words, identical to the unstalled run.
- **Reset mid-operation.** Assert rst_n=0 asynchronously after 2 words are accepted.
  - All outputs read 0 immediately.
  - A new start then runs a clean A=1, B=1 add: words 0x0002, 0, 0, 0.
- **Ignored start.** Pulse start with sub=1 during RUN of an add.
  - The result stays the add result and op_q is unchanged.
